// File: rtl/tl_ul_arb2.sv
// 2:1 TL-UL arbiter: round-robin on channel A with valid-stability lock,
// channel D routed back by the source-ID tag bit, per-master in-flight tracking.
module tl_ul_arb2_cnt #(
  parameter int MAX_OUT = 4,
  parameter int CW      = $clog2(MAX_OUT + 1)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          i_inc,
  input  logic          i_dec,
  output logic [CW-1:0] o_cnt,
  output logic          o_underflow
);
  logic [CW-1:0] r_cnt;

  // A response with nothing outstanding is a protocol error; the count holds at 0.
  assign o_underflow = i_dec && (r_cnt == '0);
  assign o_cnt       = r_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                              r_cnt <= '0;
    else if (i_inc && !i_dec)                  r_cnt <= r_cnt + CW'(1);
    else if (i_dec && !i_inc && r_cnt != '0)   r_cnt <= r_cnt - CW'(1);
  end
endmodule

module tl_ul_arb2 #(
  parameter int SRC_W   = 2,
  parameter int MAX_OUT = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  // master 0
  input  logic             m0_a_valid,
  output logic             m0_a_ready,
  input  logic [2:0]       m0_a_opcode,
  input  logic [2:0]       m0_a_param,
  input  logic [1:0]       m0_a_size,
  input  logic [SRC_W-1:0] m0_a_source,
  input  logic [31:0]      m0_a_address,
  input  logic [3:0]       m0_a_mask,
  input  logic [31:0]      m0_a_data,
  output logic             m0_d_valid,
  input  logic             m0_d_ready,
  output logic [2:0]       m0_d_opcode,
  output logic [1:0]       m0_d_param,
  output logic [1:0]       m0_d_size,
  output logic [SRC_W-1:0] m0_d_source,
  output logic [31:0]      m0_d_data,
  output logic             m0_d_denied,
  output logic             m0_d_corrupt,
  // master 1
  input  logic             m1_a_valid,
  output logic             m1_a_ready,
  input  logic [2:0]       m1_a_opcode,
  input  logic [2:0]       m1_a_param,
  input  logic [1:0]       m1_a_size,
  input  logic [SRC_W-1:0] m1_a_source,
  input  logic [31:0]      m1_a_address,
  input  logic [3:0]       m1_a_mask,
  input  logic [31:0]      m1_a_data,
  output logic             m1_d_valid,
  input  logic             m1_d_ready,
  output logic [2:0]       m1_d_opcode,
  output logic [1:0]       m1_d_param,
  output logic [1:0]       m1_d_size,
  output logic [SRC_W-1:0] m1_d_source,
  output logic [31:0]      m1_d_data,
  output logic             m1_d_denied,
  output logic             m1_d_corrupt,
  // shared slave port
  output logic             s_a_valid,
  input  logic             s_a_ready,
  output logic [2:0]       s_a_opcode,
  output logic [2:0]       s_a_param,
  output logic [1:0]       s_a_size,
  output logic [SRC_W:0]   s_a_source,
  output logic [31:0]      s_a_address,
  output logic [3:0]       s_a_mask,
  output logic [31:0]      s_a_data,
  input  logic             s_d_valid,
  output logic             s_d_ready,
  input  logic [2:0]       s_d_opcode,
  input  logic [1:0]       s_d_param,
  input  logic [1:0]       s_d_size,
  input  logic [SRC_W:0]   s_d_source,
  input  logic [31:0]      s_d_data,
  input  logic             s_d_denied,
  input  logic             s_d_corrupt,
  output logic             busy,
  output logic             err
);
  localparam int CW = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_OUT);

  logic          r_lock, r_lock_id, r_prio, r_err;
  logic [CW-1:0] w_cnt0, w_cnt1;
  logic          w_uf0, w_uf1;
  logic          w_elig0, w_elig1, w_grant, w_sel_elig;
  logic          w_a_fire, w_d_fire, w_route;

  assign w_elig0 = m0_a_valid && (w_cnt0 < MAX_C);
  assign w_elig1 = m1_a_valid && (w_cnt1 < MAX_C);

  always_comb begin
    w_grant = r_prio;
    if (r_lock)                     w_grant = r_lock_id;
    else if (w_elig0 && !w_elig1)   w_grant = 1'b0;
    else if (w_elig1 && !w_elig0)   w_grant = 1'b1;
  end

  // Gated by reset_n so the shared port goes quiet the instant reset asserts.
  assign w_sel_elig = w_grant ? w_elig1 : w_elig0;
  assign s_a_valid  = w_sel_elig && reset_n;
  assign w_a_fire   = s_a_valid && s_a_ready;
  assign m0_a_ready = w_a_fire && !w_grant;
  assign m1_a_ready = w_a_fire &&  w_grant;

  assign s_a_opcode  = w_grant ? m1_a_opcode  : m0_a_opcode;
  assign s_a_param   = w_grant ? m1_a_param   : m0_a_param;
  assign s_a_size    = w_grant ? m1_a_size    : m0_a_size;
  assign s_a_source  = {w_grant, (w_grant ? m1_a_source : m0_a_source)};
  assign s_a_address = w_grant ? m1_a_address : m0_a_address;
  assign s_a_mask    = w_grant ? m1_a_mask    : m0_a_mask;
  assign s_a_data    = w_grant ? m1_a_data    : m0_a_data;

  assign w_route    = s_d_source[SRC_W];
  assign m0_d_valid = s_d_valid && !w_route;
  assign m1_d_valid = s_d_valid &&  w_route;
  assign s_d_ready  = w_route ? m1_d_ready : m0_d_ready;
  assign w_d_fire   = s_d_valid && s_d_ready;

  assign m0_d_opcode  = s_d_opcode;   assign m1_d_opcode  = s_d_opcode;
  assign m0_d_param   = s_d_param;    assign m1_d_param   = s_d_param;
  assign m0_d_size    = s_d_size;     assign m1_d_size    = s_d_size;
  assign m0_d_source  = s_d_source[SRC_W-1:0];
  assign m1_d_source  = s_d_source[SRC_W-1:0];
  assign m0_d_data    = s_d_data;     assign m1_d_data    = s_d_data;
  assign m0_d_denied  = s_d_denied;   assign m1_d_denied  = s_d_denied;
  assign m0_d_corrupt = s_d_corrupt;  assign m1_d_corrupt = s_d_corrupt;

  tl_ul_arb2_cnt #(.MAX_OUT(MAX_OUT), .CW(CW)) u_cnt0 (
    .clock(clock), .reset_n(reset_n),
    .i_inc(w_a_fire && !w_grant), .i_dec(w_d_fire && !w_route),
    .o_cnt(w_cnt0), .o_underflow(w_uf0)
  );
  tl_ul_arb2_cnt #(.MAX_OUT(MAX_OUT), .CW(CW)) u_cnt1 (
    .clock(clock), .reset_n(reset_n),
    .i_inc(w_a_fire && w_grant), .i_dec(w_d_fire && w_route),
    .o_cnt(w_cnt1), .o_underflow(w_uf1)
  );

  // Lock holds a stalled grant so an offered request is never withdrawn.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_lock    <= 1'b0;
      r_lock_id <= 1'b0;
      r_prio    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_lock    <= s_a_valid && !s_a_ready;
      r_lock_id <= w_grant;
      if (w_a_fire) r_prio <= ~w_grant;
      if (w_uf0 || w_uf1 || (w_a_fire && s_a_size > 2'd2)) r_err <= 1'b1;
    end
  end

  assign busy = (w_cnt0 != '0) || (w_cnt1 != '0);
  assign err  = r_err;
endmodule
